// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU
//               with RISC-V semantics. It produces one quotient bit per cycle
//               and uses a valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res
);

    localparam int               c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic              out_valid_q;
    logic [WIDTH-1:0]  res_q;
    logic              is_rem_q;
    logic              quo_sign_q;
    logic              rem_sign_q;
    logic [WIDTH-1:0]  quo_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  div_q;
    logic [c_CW-1:0]   cnt_q;

    // Operand decode used only at the accept edge
    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [WIDTH-1:0]  w_a_mag;
    logic [WIDTH-1:0]  w_b_mag;
    logic              w_b_zero;
    logic              w_ovf;
    logic [WIDTH-1:0]  w_special_res;

    // One restoring step
    logic [WIDTH:0]    w_rem_sh;
    logic [WIDTH:0]    w_trial;
    logic [WIDTH-1:0]  rem_d;
    logic [WIDTH-1:0]  quo_d;
    logic [WIDTH-1:0]  w_sel;
    logic              w_neg_res;
    logic [WIDTH-1:0]  w_result;

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign res       = res_q;

    // Only DIV/REM (op[0]==0) treat the operands as signed
    assign w_signed      = ~op[0];
    assign w_a_neg       = w_signed & a[WIDTH-1];
    assign w_b_neg       = w_signed & b[WIDTH-1];
    assign w_a_mag       = w_a_neg ? (~a + WIDTH'(1)) : a;
    assign w_b_mag       = w_b_neg ? (~b + WIDTH'(1)) : b;
    assign w_b_zero      = (b == '0);
    assign w_ovf         = w_signed && (a == c_MIN) && (b == c_ONES);
    assign w_special_res = w_b_zero ? (op[1] ? a : c_ONES)
                                    : (op[1] ? '0 : c_MIN);

    // The bit shifted out of the remainder is kept as the extra MSB, so a
    // divisor above 2^(WIDTH-1) still compares correctly at WIDTH+1 bits.
    assign w_rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, div_q};

    // Next remainder/quotient for one iteration, plus the sign-corrected result
    always_comb begin
        rem_d = w_rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            rem_d = w_trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
        w_sel     = is_rem_q ? rem_d      : quo_d;
        w_neg_res = is_rem_q ? rem_sign_q : quo_sign_q;
        w_result  = w_neg_res ? (~w_sel + WIDTH'(1)) : w_sel;
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            is_rem_q    <= 1'b0;
            quo_sign_q  <= 1'b0;
            rem_sign_q  <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        is_rem_q   <= op[1];
                        quo_sign_q <= w_a_neg ^ w_b_neg;
                        rem_sign_q <= w_a_neg;
                        quo_q      <= w_a_mag;
                        rem_q      <= '0;
                        div_q      <= w_b_mag;
                        cnt_q      <= '0;
                        if (w_b_zero || w_ovf) begin
                            res_q       <= w_special_res;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            state_q     <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else begin
                        quo_q <= quo_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + c_CW'(1);
                        if (cnt_q == c_LAST) begin
                            res_q       <= w_result;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Flush wins over a simultaneous handshake: result dropped
                    if (flush || out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Scoreboard bench for div_unit with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;

    localparam logic [1:0] c_DIV  = 2'b00;
    localparam logic [1:0] c_DIVU = 2'b01;
    localparam logic [1:0] c_REM  = 2'b10;
    localparam logic [1:0] c_REMU = 2'b11;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per delivered result
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got 0x%08h expected no result", res);
                end else begin
                    check(name_q.pop_front(), res, exp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge
    task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        check({nm, " ready_before_issue"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        op       = 2'($urandom_range(0, 3));
    endtask

    // Counts edges after the accept edge until out_valid rises
    task automatic wait_result(input string nm, input int exp_lat);
        int lat     = 0;
        bit busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;
        check({nm, " latency"}, 32'(lat), 32'(exp_lat));
        check({nm, " in_ready_low_while_busy"}, {31'b0, busy_ok}, 32'd1);
    endtask

    task automatic run(input string nm, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        issue(nm, o, x, y);
        wait_result(nm, exp_lat);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stable_ok;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = '0;
        #12;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset res", res, 32'd0);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Normal operations: 32 edges from accept to out_valid
        run("DIV -7/2",            c_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32);
        run("REM -7/2",            c_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32);
        run("DIVU ffffffff/3",     c_DIVU, 32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 32);
        run("REMU 100/7",          c_REMU, 32'd100,       32'd7,         32'd2,         32);
        run("DIVU big divisor",    c_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         32);
        run("REMU big divisor",    c_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32);
        run("DIV 5/-1",            c_DIV,  32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 32);

        // Special cases: out_valid already high right after the accept edge
        run("DIV 1234/0",          c_DIV,  32'd1234,      32'd0,         32'hFFFF_FFFF, 0);
        run("REMU 1234/0",         c_REMU, 32'd1234,      32'd0,         32'd1234,      0);
        run("DIV overflow",        c_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run("REM overflow",        c_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0);

        // Backpressure: result held for 10 cycles, new request refused
        out_ready = 1'b0;
        exp_q.push_back(32'hFFFF_FFF2);
        name_q.push_back("DIV 100/-7 backpressure");
        issue("DIV 100/-7", c_DIV, 32'd100, 32'hFFFF_FFF9);
        wait_result("DIV 100/-7", 32);
        stable_ok = 1'b1;
        in_valid  = 1'b1;
        op        = c_DIVU;
        a         = 32'd50;
        b         = 32'd5;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || res !== 32'hFFFF_FFF2 || in_ready !== 1'b0) stable_ok = 1'b0;
        end
        in_valid = 1'b0;
        check("backpressure hold", {31'b0, stable_ok}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("handshake out_valid", {31'b0, out_valid}, 32'd0);
        check("handshake in_ready", {31'b0, in_ready}, 32'd1);

        // Flush during CALC cycle 10
        issue("flush calc", c_DIVU, 32'hFFFF_FFFF, 32'd3);
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush calc out_valid", {31'b0, out_valid}, 32'd0);
        check("flush calc in_ready", {31'b0, in_ready}, 32'd1);
        stable_ok = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stable_ok = 1'b0;
        end
        check("flush calc no result", {31'b0, stable_ok}, 32'd1);

        // Flush in IDLE blocks acceptance
        in_valid = 1'b1;
        flush    = 1'b1;
        op       = c_DIVU;
        a        = 32'd7;
        b        = 32'd1;
        stable_ok = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (in_ready !== 1'b1) stable_ok = 1'b0;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush idle blocks accept", {31'b0, stable_ok}, 32'd1);
        run("DIVU 50/5 after flush", c_DIVU, 32'd50, 32'd5, 32'd10, 32);

        // Flush in DONE together with out_ready drops the result
        out_ready = 1'b0;
        issue("flush done", c_DIVU, 32'd9, 32'd0);
        wait_result("flush done", 0);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush done out_valid", {31'b0, out_valid}, 32'd0);
        check("flush done in_ready", {31'b0, in_ready}, 32'd1);

        // Reset at CALC cycle 20
        run("DIVU 77/7", c_DIVU, 32'd77, 32'd7, 32'd11, 32);
        issue("reset calc", c_DIVU, 32'd1000, 32'd3);
        repeat (20) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("reset calc out_valid", {31'b0, out_valid}, 32'd0);
        check("reset calc res", res, 32'd0);
        check("reset calc in_ready", {31'b0, in_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("DIVU 50/5 after reset", c_DIVU, 32'd50, 32'd5, 32'd10, 32);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divide/remainder unit, the inverse companion of the single-cycle ALU multiply.
- Executes DIV, DIVU, REM and REMU with RISC-V semantics using a radix-2 restoring algorithm, one quotient bit per cycle.
- Sits beside the ALU in the execute stage; the pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand and result width; counter width is clog2(WIDTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request.
- a  input  WIDTH  dividend.
- b  input  WIDTH  divisor.
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- flush  input  1  abort current operation.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- res  output  WIDTH  quotient or remainder.

Behaviour:
- Reset: rst_n low forces state IDLE asynchronously.
  - Reset values: out_valid=0, res=0, internal quotient, remainder, divisor and counter registers=0.
  - in_ready=1 (it is decoded as state==IDLE).
- States: IDLE, CALC, DONE. in_ready is high only in IDLE, so there is no back-to-back accept.
- Accept: on a rising edge with in_valid&&in_ready&&!flush, latch op, the sign flags and the operand magnitudes.
  - Signed ops take absolute values; the quotient sign is a[31]^b[31] and the remainder sign is a[31].
  - Unsigned ops use the raw operands.
- Special cases at the accept edge skip CALC and go directly to DONE; out_valid is high the next cycle.
  - b==0: quotient = all ones (DIV and DIVU); remainder = a (REM and REMU).
  - Signed overflow, a==0x80000000 and b==0xFFFFFFFF with DIV/REM: quotient = 0x80000000, remainder = 0.
- CALC iteration, one per cycle, for exactly WIDTH cycles with the counter running 0..WIDTH-1:
  - Shift {rem,quo} left by 1.
  - Trial = rem - divisor, computed at WIDTH+1 bits.
  - If the trial is non-negative: rem = trial and quo[0] = 1.
- Exit from CALC: on the edge completing iteration WIDTH-1, sign-correct the selected result, register it into res, and set state DONE and out_valid=1.
  - Latency is WIDTH (32) cycles from the accept edge to out_valid high.
- DONE: res and out_valid are held stable while out_ready is low (backpressure for any number of cycles).
  - On an edge with out_valid&&out_ready: out_valid=0, state IDLE, in_ready=1 the next cycle. res keeps its last value.
- flush:
  - In CALC or DONE, the next edge returns the unit to IDLE with out_valid=0 and no result delivered.
  - In IDLE, flush blocks acceptance even when in_valid is high.
  - flush together with out_ready in DONE: treat as flush; the result is considered dropped.
- Reset mid-operation aborts immediately. No partial result appears after rst_n rises.
- a, b and op are sampled only at the accept edge; changes during CALC have no effect.
- Arithmetic: all internal magnitudes are unsigned WIDTH bits. The negation for sign correction is two's complement modulo 2^WIDTH.

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2 -> out_valid exactly 32 cycles after the accept edge, res=0xFFFFFFFD (-3). REM with the same operands -> res=0xFFFFFFFF (-1).
- DIVU a=0xFFFFFFFF, b=3 -> res=0x55555555. REMU a=100, b=7 -> res=2. Check in_ready=0 throughout CALC and DONE.
- Divide by zero:
  - DIV 1234/0 -> res=0xFFFFFFFF.
  - REMU 1234/0 -> res=1234.
  - out_valid is high 1 cycle after accept, and CALC is skipped.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> res=0x80000000. REM with the same operands -> res=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> res and out_valid stay stable. Then pulse out_ready -> IDLE next cycle; a new request is accepted only after that.
- Abort:
  - Assert flush at CALC cycle 10 -> IDLE next edge, no out_valid.
  - Separately, pull rst_n low at CALC cycle 20 -> out_valid=0 and res=0 immediately.
  - After either abort, a following DIVU 50/5 returns 10.
